ram_arbiter: RTL and testbench

Shares the single RAM port among NREQ memory requesters (per-core icache and coherence/dcache paths) with round-robin fairness. It holds a grant across multi-word block transfers and times out stalled accesses. It sits between the requester-side buses and the RAM model, and drives ramREN/ramWEN/ramaddr/ramstore from the granted requester only.

---
 rtl/ram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin owner of the single RAM port shared by the
// per-core icache and dcache requesters. It holds the grant across locked
// block transfers and gives up a stalled or failed access with an err pulse.

package ram_arbiter_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;
endpackage

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int TIMEOUT     = 64,
    parameter int LOCK_WINDOW = 4
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NREQ-1:0]            req_ren,
    input  logic [NREQ-1:0]            req_wen,
    input  logic [NREQ-1:0]            req_lock,
    input  logic [NREQ-1:0][31:0]      req_addr,
    input  logic [NREQ-1:0][31:0]      req_store,
    output logic [NREQ-1:0]            req_wait,
    output logic [NREQ-1:0][31:0]      req_load,
    output logic [NREQ-1:0]            grant,
    output logic                       ramREN,
    output logic                       ramWEN,
    output logic [31:0]                ramaddr,
    output logic [31:0]                ramstore,
    input  logic [31:0]                ramload,
    input  ramstate_t                  ramstate,
    output logic                       err,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] err_id
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(LOCK_WINDOW + 1);

    typedef enum logic [1:0] {IDLE, GRANT, HOLD, ERR} state_t;

    state_t            state;
    logic [IW-1:0]     owner;
    logic [IW-1:0]     ptr;
    logic [TW-1:0]     tcnt;
    logic [TW-1:0]     tcnt_next;
    logic [LW-1:0]     lcnt;
    logic [LW-1:0]     lcnt_next;
    logic [NREQ-1:0]   active;
    logic              found;
    logic [IW-1:0]     win;
    logic [IW-1:0]     cand;

    assign active    = req_ren | req_wen;
    assign tcnt_next = (tcnt == {TW{1'b1}}) ? tcnt : tcnt + TW'(1);
    assign lcnt_next = (lcnt == {LW{1'b1}}) ? lcnt : lcnt + LW'(1);

    // Round-robin pick: first active requester after the last served one, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(ptr) + i) % NREQ);
            if (!found && active[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Ownership FSM: arbitration, per-word completion, lock hold, timeout and error.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            grant  <= '0;
            owner  <= '0;
            ptr    <= IW'(NREQ - 1);
            tcnt   <= '0;
            lcnt   <= '0;
            err    <= 1'b0;
            err_id <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    lcnt <= '0;
                    if (found) begin
                        state <= GRANT;
                        grant <= NREQ'(1) << win;
                        owner <= win;
                    end
                end
                GRANT: begin
                    if (!active[owner]) begin
                        state <= IDLE;
                        grant <= '0;
                        tcnt  <= '0;
                    end else if (ramstate == ACCESS) begin
                        tcnt <= '0;
                        if (req_lock[owner]) begin
                            state <= HOLD;
                            lcnt  <= '0;
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                            ptr   <= owner;
                        end
                    end else if (ramstate == ERROR || tcnt_next == TW'(TIMEOUT)) begin
                        state  <= ERR;
                        tcnt   <= tcnt_next;
                        err    <= 1'b1;
                        err_id <= owner;
                        ptr    <= owner;
                    end else begin
                        tcnt <= tcnt_next;
                    end
                end
                HOLD: begin
                    if (active[owner]) begin
                        state <= GRANT;
                        lcnt  <= '0;
                    end else if (!req_lock[owner] || lcnt_next == LW'(LOCK_WINDOW)) begin
                        state <= IDLE;
                        grant <= '0;
                        ptr   <= owner;
                        lcnt  <= '0;
                    end else begin
                        lcnt <= lcnt_next;
                    end
                end
                ERR: begin
                    state <= IDLE;
                    grant <= '0;
                    tcnt  <= '0;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // RAM strobes and requester responses follow the live inputs of the owner only while granted.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        req_wait = '1;
        req_load = '0;
        if (state == GRANT) begin
            ramaddr         = req_addr[owner];
            ramWEN          = req_wen[owner];
            ramREN          = req_ren[owner] & ~req_wen[owner];
            ramstore        = req_wen[owner] ? req_store[owner] : 32'h0;
            req_wait[owner] = (ramstate != ACCESS);
            req_load[owner] = ramload;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scenario tasks plus randomized traffic for ram_arbiter,
// checked against a round-robin model kept in plain bench arithmetic.

module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int NREQ = 4;

    logic                  CLK;
    logic                  nRST;
    logic [NREQ-1:0]       req_ren;
    logic [NREQ-1:0]       req_wen;
    logic [NREQ-1:0]       req_lock;
    logic [NREQ-1:0][31:0] req_addr;
    logic [NREQ-1:0][31:0] req_store;
    logic [NREQ-1:0]       req_wait;
    logic [NREQ-1:0][31:0] req_load;
    logic [NREQ-1:0]       grant;
    logic                  ramREN;
    logic                  ramWEN;
    logic [31:0]           ramaddr;
    logic [31:0]           ramstore;
    logic [31:0]           ramload;
    ramstate_t             ramstate;
    logic                  err;
    logic [1:0]            err_id;

    int checks = 0;
    int errors = 0;
    int mptr   = NREQ - 1;

    ram_arbiter #(.NREQ(NREQ), .TIMEOUT(64), .LOCK_WINDOW(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_ren(req_ren), .req_wen(req_wen), .req_lock(req_lock),
        .req_addr(req_addr), .req_store(req_store),
        .req_wait(req_wait), .req_load(req_load), .grant(grant),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err), .err_id(err_id)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: next owner is the nearest requesting lane after the last served one.
    function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] mask, input int p);
        logic [1:0] c;
        for (int d = 1; d <= NREQ; d++) begin
            c = 2'((p + d) % NREQ);
            if (mask[c]) return c;
        end
        return 2'd0;
    endfunction

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        req_ren  = '0;
        req_wen  = '0;
        req_lock = '0;
        ramstate = FREE;
        ramload  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        req_addr  = '0;
        req_store = '0;
        nRST = 1'b0;
        repeat (2) cyc();
        checks++;
        if (grant !== 4'b0000 || req_wait !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL reset_grant_wait: grant=%b wait=%b, want 0000/1111", grant, req_wait);
        end
        checks++;
        if ({ramREN, ramWEN} !== 2'b00 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_ram: ren=%b wen=%b addr=%h store=%h, want all 0", ramREN, ramWEN, ramaddr, ramstore);
        end
        checks++;
        if (req_load !== '0) begin
            errors++;
            $display("[TB] FAIL reset_load: got %h, want 0", req_load);
        end
        checks++;
        if (err !== 1'b0 || err_id !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_err: err=%b id=%0d, want 0/0", err, err_id);
        end
        nRST = 1'b1;
        mptr = NREQ - 1;
        cyc();
    endtask

    task automatic test_single_read();
        req_ren[1]  = 1'b1;
        req_addr[1] = 32'h100;
        #1;
        checks++;
        if (grant !== 4'b0000 || ramREN !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_idle: grant=%b ren=%b, want 0000/0", grant, ramREN);
        end
        cyc();
        for (int b = 0; b < 3; b++) begin
            ramstate = BUSY;
            #1;
            checks++;
            if (grant !== 4'b0010 || ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h100 || req_wait !== 4'b1111) begin
                errors++;
                $display("[TB] FAIL single_busy%0d: grant=%b ren=%b wen=%b addr=%h wait=%b, want 0010/1/0/100/1111",
                         b, grant, ramREN, ramWEN, ramaddr, req_wait);
            end
            cyc();
        end
        ramstate = ACCESS;
        ramload  = 32'hDEADBEEF;
        #1;
        checks++;
        if (req_wait !== 4'b1101 || req_load[1] !== 32'hDEADBEEF || req_load[0] !== 32'h0) begin
            errors++;
            $display("[TB] FAIL single_access: wait=%b load1=%h load0=%h, want 1101/deadbeef/0", req_wait, req_load[1], req_load[0]);
        end
        cyc();
        req_ren[1] = 1'b0;
        ramstate   = FREE;
        ramload    = '0;
        mptr       = 1;
        #1;
        checks++;
        if (grant !== 4'b0000 || req_wait !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL single_done: grant=%b wait=%b, want 0000/1111", grant, req_wait);
        end
        cyc();
    endtask

    task automatic test_all_lanes();
        logic [1:0] w;
        for (int l = 0; l < NREQ; l++) req_addr[l] = 32'(l * 16);
        req_ren = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w = rr_pick(req_ren, mptr);
            ramstate = FREE;
            cyc();
            ramstate = ACCESS;
            #1;
            checks++;
            if (grant !== (4'b0001 << w) || ramaddr !== 32'(w * 16) || req_wait !== ~(4'b0001 << w)) begin
                errors++;
                $display("[TB] FAIL all_lanes_%0d: grant=%b addr=%h wait=%b, want lane %0d", k, grant, ramaddr, req_wait, w);
            end
            cyc();
            if (k != 0) req_ren[w] = 1'b0;
            mptr = int'(w);
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_locked_write();
        int wcount = 0;
        req_wen[3]   = 1'b1;
        req_lock[3]  = 1'b1;
        req_addr[3]  = 32'h200;
        req_store[3] = 32'hA5A50001;
        req_ren[0]   = 1'b1;
        req_addr[0]  = 32'h40;
        cyc();
        ramstate = BUSY;
        #1;
        checks++;
        if (grant !== 4'b1000 || ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h200 || ramstore !== 32'hA5A50001) begin
            errors++;
            $display("[TB] FAIL lock_word1: grant=%b wen=%b ren=%b addr=%h store=%h", grant, ramWEN, ramREN, ramaddr, ramstore);
        end
        cyc();
        ramstate = ACCESS;
        #1;
        if (ramWEN && ramstate == ACCESS) wcount++;
        checks++;
        if (req_wait !== 4'b0111) begin
            errors++;
            $display("[TB] FAIL lock_word1_done: wait=%b, want 0111", req_wait);
        end
        cyc();
        req_addr[3]  = 32'h204;
        req_store[3] = 32'hA5A50002;
        req_lock[3]  = 1'b0;
        ramstate     = FREE;
        #1;
        checks++;
        if (grant !== 4'b1000 || {ramREN, ramWEN} !== 2'b00 || req_wait !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL lock_hold: grant=%b ren=%b wen=%b wait=%b, want 1000/0/0/1111", grant, ramREN, ramWEN, req_wait);
        end
        cyc();
        ramstate = ACCESS;
        #1;
        if (ramWEN && ramstate == ACCESS) wcount++;
        checks++;
        if (grant !== 4'b1000 || ramWEN !== 1'b1 || ramaddr !== 32'h204 || ramstore !== 32'hA5A50002 || req_wait !== 4'b0111) begin
            errors++;
            $display("[TB] FAIL lock_word2: grant=%b wen=%b addr=%h store=%h wait=%b", grant, ramWEN, ramaddr, ramstore, req_wait);
        end
        cyc();
        req_wen[3] = 1'b0;
        ramstate   = FREE;
        #1;
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL lock_release: grant=%b, want 0000", grant);
        end
        cyc();
        ramstate = ACCESS;
        #1;
        checks++;
        if (grant !== 4'b0001 || ramREN !== 1'b1 || ramaddr !== 32'h40) begin
            errors++;
            $display("[TB] FAIL lock_next_i0: grant=%b ren=%b addr=%h, want 0001/1/40", grant, ramREN, ramaddr);
        end
        cyc();
        idle_inputs();
        mptr = 0;
        checks++;
        if (wcount != 2) begin
            errors++;
            $display("[TB] FAIL lock_wen_count: got %0d, want 2", wcount);
        end
        cyc();
    endtask

    task automatic test_lock_window();
        req_ren[1]  = 1'b1;
        req_lock[1] = 1'b1;
        req_addr[1] = 32'h300;
        req_ren[2]  = 1'b1;
        req_addr[2] = 32'h400;
        cyc();
        ramstate = ACCESS;
        ramload  = 32'h11112222;
        #1;
        checks++;
        if (grant !== 4'b0010 || req_wait !== 4'b1101 || req_load[1] !== 32'h11112222) begin
            errors++;
            $display("[TB] FAIL window_word: grant=%b wait=%b load=%h", grant, req_wait, req_load[1]);
        end
        cyc();
        req_ren[1] = 1'b0;
        ramstate   = FREE;
        for (int h = 1; h <= 4; h++) begin
            #1;
            checks++;
            if (grant !== 4'b0010 || req_wait !== 4'b1111 || {ramREN, ramWEN} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL window_hold%0d: grant=%b wait=%b strobes=%b%b", h, grant, req_wait, ramREN, ramWEN);
            end
            cyc();
        end
        #1;
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL window_release: grant=%b, want 0000", grant);
        end
        cyc();
        ramstate = ACCESS;
        #1;
        checks++;
        if (grant !== 4'b0100 || ramaddr !== 32'h400 || ramREN !== 1'b1) begin
            errors++;
            $display("[TB] FAIL window_next_i1: grant=%b addr=%h ren=%b", grant, ramaddr, ramREN);
        end
        cyc();
        idle_inputs();
        mptr = 2;
        cyc();
    endtask

    task automatic test_timeout();
        req_ren[2]  = 1'b1;
        req_addr[2] = 32'h500;
        ramstate    = BUSY;
        cyc();
        for (int k = 1; k <= 64; k++) begin
            checks++;
            if ({err, grant, req_wait} !== {1'b0, 4'b0100, 4'b1111}) begin
                errors++;
                $display("[TB] FAIL timeout_wait%0d: err=%b grant=%b wait=%b", k, err, grant, req_wait);
            end
            cyc();
        end
        checks++;
        if (err !== 1'b1 || err_id !== 2'd2 || ramREN !== 1'b0 || req_wait !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL timeout_err: err=%b id=%0d ren=%b wait=%b, want 1/2/0/1111", err, err_id, ramREN, req_wait);
        end
        req_ren[2] = 1'b0;
        ramstate   = FREE;
        cyc();
        mptr = 2;
        checks++;
        if (err !== 1'b0 || err_id !== 2'd2 || grant !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL timeout_after: err=%b id=%0d grant=%b, want 0/2/0000", err, err_id, grant);
        end
        req_ren[0] = 1'b1;
        cyc();
        ramstate = ERROR;
        #1;
        checks++;
        if (err !== 1'b0 || grant !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL error_grant: err=%b grant=%b, want 0/0001", err, grant);
        end
        cyc();
        checks++;
        if (err !== 1'b1 || err_id !== 2'd0) begin
            errors++;
            $display("[TB] FAIL error_err: err=%b id=%0d, want 1/0", err, err_id);
        end
        idle_inputs();
        cyc();
        mptr = 0;
        checks++;
        if (err !== 1'b0 || grant !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL error_after: err=%b grant=%b, want 0/0000", err, grant);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0]       mask;
        logic [NREQ-1:0][31:0] exp_ld;
        logic [1:0]            w;
        logic                  wr;
        int                    busy;
        bit                    abort;
        for (int it = 0; it < 40; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int l = 0; l < NREQ; l++) begin
                req_addr[l]  = $urandom();
                req_store[l] = $urandom();
            end
            req_ren  = mask;
            req_wen  = mask & 4'($urandom());
            req_lock = '0;
            ramstate = FREE;
            w  = rr_pick(mask, mptr);
            wr = req_wen[w];
            #1;
            checks++;
            if (grant !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL rand_idle%0d: grant=%b, want 0000", it, grant);
            end
            cyc();
            #1;
            checks++;
            if (grant !== (4'b0001 << w) || ramaddr !== req_addr[w] || ramWEN !== wr || ramREN !== ~wr ||
                ramstore !== (wr ? req_store[w] : 32'h0)) begin
                errors++;
                $display("[TB] FAIL rand_grant%0d: grant=%b addr=%h ren=%b wen=%b store=%h, want lane %0d wr=%b",
                         it, grant, ramaddr, ramREN, ramWEN, ramstore, w, wr);
            end
            busy  = $urandom_range(0, 3);
            abort = ($urandom_range(0, 4) == 0);
            for (int b = 0; b < busy; b++) begin
                ramstate = ($urandom_range(0, 1) != 0) ? BUSY : FREE;
                #1;
                checks++;
                if (req_wait !== 4'b1111) begin
                    errors++;
                    $display("[TB] FAIL rand_stall%0d: wait=%b, want 1111", it, req_wait);
                end
                cyc();
            end
            if (abort) begin
                req_ren[w] = 1'b0;
                req_wen[w] = 1'b0;
                ramstate   = BUSY;
                #1;
                checks++;
                if ({ramREN, ramWEN} !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL rand_abort%0d: ren=%b wen=%b, want 0/0", it, ramREN, ramWEN);
                end
                cyc();
            end else begin
                ramstate = ACCESS;
                ramload  = $urandom();
                exp_ld    = '0;
                exp_ld[w] = ramload;
                #1;
                checks++;
                if (req_wait !== ~(4'b0001 << w) || req_load !== exp_ld) begin
                    errors++;
                    $display("[TB] FAIL rand_done%0d: wait=%b load=%h, want lane %0d data %h", it, req_wait, req_load, w, ramload);
                end
                cyc();
                mptr = int'(w);
            end
            idle_inputs();
        end
        #1;
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL rand_end: grant=%b, want 0000", grant);
        end
        cyc();
    endtask

    task automatic test_async_reset();
        req_wen[1]   = 1'b1;
        req_addr[1]  = 32'h600;
        req_store[1] = 32'h12345678;
        cyc();
        ramstate = BUSY;
        #1;
        checks++;
        if (ramWEN !== 1'b1 || grant !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL areset_pre: wen=%b grant=%b, want 1/0010", ramWEN, grant);
        end
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (ramWEN !== 1'b0 || grant !== 4'b0000 || req_wait !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL areset_drop: wen=%b grant=%b wait=%b, want 0/0000/1111", ramWEN, grant, req_wait);
        end
        cyc();
        checks++;
        if (ramWEN !== 1'b0 || req_wait !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL areset_held: wen=%b wait=%b, want 0/1111", ramWEN, req_wait);
        end
        idle_inputs();
        nRST = 1'b1;
        mptr = NREQ - 1;
        cyc();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nRST = 1'b0;
        idle_inputs();
        req_addr  = '0;
        req_store = '0;
        test_reset();
        test_single_read();
        test_reset();
        test_all_lanes();
        test_locked_write();
        test_lock_window();
        test_timeout();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
